// File: rtl/lvds_rx_pkg.sv
// Shared LVDS RX definitions: frame layout, sync patterns and gate state encodings.
// Used by lvds_rx and the frame gate so both sides agree on the word format.
package lvds_rx_pkg;

    localparam logic [1:0] SYNC_I = 2'b10;
    localparam logic [1:0] SYNC_Q = 2'b01;

    localparam int FRM_I_SYNC_HI = 31;
    localparam int FRM_I_SYNC_LO = 30;
    localparam int FRM_I_HI      = 29;
    localparam int FRM_I_LO      = 17;
    localparam int FRM_GAP_BIT   = 16;
    localparam int FRM_Q_SYNC_HI = 15;
    localparam int FRM_Q_SYNC_LO = 14;
    localparam int FRM_Q_HI      = 13;
    localparam int FRM_Q_LO      = 1;
    localparam int FRM_SYNC_BIT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b11
    } rx_state_e;

    function automatic logic frame_ok(input logic [31:0] w);
        return (w[FRM_I_SYNC_HI:FRM_I_SYNC_LO] == SYNC_I) &&
               !w[FRM_GAP_BIT] &&
               (w[FRM_Q_SYNC_HI:FRM_Q_SYNC_LO] == SYNC_Q);
    endfunction

endpackage

// File: rtl/rx_skid_fifo.sv
// Small synchronous FIFO absorbing RX FIFO-full stalls; registered head output.
// A read and a write may share a cycle even when full (read sees the old head).
module rx_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         full,
    output logic         empty,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic [W-1:0]  rd_data_q, rd_data_d;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_valid_d = 1'b1;
                rd_data_d  = mem[rd_ptr_q];
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is not reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: rtl/lvds_rx_frame_gate.sv
// RX frame gate: validates I/Q frames, stamps sync, decimates by 2^N and
// buffers words ahead of the RX sample FIFO, owning all RX backpressure.
module lvds_rx_frame_gate
    import lvds_rx_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             i_ddr_clk,
    input  logic             i_rst_b,
    input  logic             i_enable,
    input  logic             i_start_on_sync,
    input  logic [1:0]       i_decim_log2,
    input  logic             i_sync_input,
    input  logic             i_word_valid,
    input  logic [31:0]      i_word_data,
    input  logic             i_fifo_full,
    input  logic             i_cnt_clear,
    output logic             o_fifo_push,
    output logic [31:0]      o_fifo_data,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_frame_err_cnt,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic             o_overflow
);
    rx_state_e        state_q, state_d;
    logic [2:0]       dec_cnt_q, dec_cnt_d;
    logic [1:0]       decim_q;
    logic             latch_q, latch_d;
    logic [CNT_W-1:0] err_q, err_d, drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic        go_idle, run, good, bad, emit, pop, accept, drop;
    logic [2:0]  dec_mask;
    logic [31:0] wr_data;
    logic        buf_full, buf_empty;

    always_comb begin
        go_idle  = !i_enable;
        run      = (state_q == ST_RUN) && i_enable;
        good     = run && i_word_valid && frame_ok(i_word_data);
        bad      = run && i_word_valid && !frame_ok(i_word_data);
        dec_mask = 3'((4'd1 << i_decim_log2) - 4'd1);
        emit     = good && (dec_cnt_q == 3'd0);
        // Head pops into the output register; a pop frees a slot for a same-cycle write.
        pop      = !buf_empty && !i_fifo_full && i_enable;
        accept   = emit && (!buf_full || pop);
        drop     = emit && buf_full && !pop;
        wr_data  = {i_word_data[31:1], latch_q | i_sync_input};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = i_start_on_sync ? ST_ARMED : ST_RUN;
            ST_ARMED: if (i_sync_input) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (go_idle) state_d = ST_IDLE;

        dec_cnt_d = dec_cnt_q;
        if (i_decim_log2 != decim_q)
            dec_cnt_d = 3'd0;
        else if (good)
            dec_cnt_d = (dec_cnt_q == dec_mask) ? 3'd0 : dec_cnt_q + 3'd1;
        if (go_idle) dec_cnt_d = 3'd0;

        latch_d = latch_q;
        if (run && i_sync_input) latch_d = 1'b1;
        if (emit || go_idle)     latch_d = 1'b0;

        err_d  = err_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (i_cnt_clear) begin
            err_d  = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (bad && !(&err_q))   err_d  = err_q + CNT_W'(1);
            if (drop && !(&drop_q)) drop_d = drop_q + CNT_W'(1);
            if (drop)               ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q   <= ST_IDLE;
            dec_cnt_q <= '0;
            decim_q   <= '0;
            latch_q   <= 1'b0;
            err_q     <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_cnt_q <= dec_cnt_d;
            decim_q   <= i_decim_log2;
            latch_q   <= latch_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    rx_skid_fifo #(.DEPTH(BUF_DEPTH), .W(32)) u_buf (
        .clk      (i_ddr_clk),
        .rst_b    (i_rst_b),
        .flush    (go_idle),
        .wr_en    (accept),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .full     (buf_full),
        .empty    (buf_empty),
        .rd_valid (o_fifo_push),
        .rd_data  (o_fifo_data)
    );

    assign o_state         = state_q;
    assign o_frame_err_cnt = err_q;
    assign o_drop_cnt      = drop_q;
    assign o_overflow      = ovf_q;

endmodule
